// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_pkg
// Description : Shared types and helpers for the FFT input reorder stage:
//               transform length, complex sample type, bank occupancy
//               state and the bit-reversal index helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    // Default transform length used by the datapath.
    localparam int FFT_N          = 8;
    // Default component width of a complex sample.
    localparam int FFT_DATA_WIDTH = 16;

    // Complex sample as carried between datapath stages.
    typedef struct packed {
        logic signed [FFT_DATA_WIDTH-1:0] re;
        logic signed [FFT_DATA_WIDTH-1:0] im;
    } cplx_t;

    // Occupancy of one ping-pong bank.
    typedef enum logic [0:0] {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } bank_state_e;

    // Reverse the low 'width' bits of 'idx'; higher bits are ignored.
    function automatic int unsigned bitrev(input int unsigned idx, input int width);
        int unsigned r;
        r = 0;
        for (int i = 0; i < width; i++) begin
            r = (r << 1) | ((idx >> i) & 32'd1);
        end
        return r;
    endfunction

endpackage : fft_pkg
`default_nettype wire

// File: rtl/fft_bank_ram.sv
`default_nettype none
// ============================================================================
// Module      : fft_bank_ram
// Description : One bank of the reorder buffer. DEPTH words of WIDTH bits,
//               one synchronous write port and one combinational read port.
//               Contents are not reset; validity is tracked by the owner.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_bank_ram
    import fft_pkg::*;
#(
    parameter int DEPTH      = FFT_N,
    parameter int WIDTH      = 2 * FFT_DATA_WIDTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en_in,
    input  logic [ADDR_WIDTH-1:0] wr_addr_in,
    input  logic [WIDTH-1:0]      wr_data_in,
    input  logic [ADDR_WIDTH-1:0] rd_addr_in,
    output logic [WIDTH-1:0]      rd_data_out
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Synchronous write of one sample word.
    always_ff @(posedge clk) begin
        if (wr_en_in) begin
            mem_q[wr_addr_in] <= wr_data_in;
        end
    end

    // Combinational read so the output register can load in the same cycle.
    assign rd_data_out = mem_q[rd_addr_in];

endmodule : fft_bank_ram
`default_nettype wire

// File: rtl/fft_bitrev_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fft_bitrev_buffer
// Description : Streaming input reorder stage of the FFT datapath. Samples
//               arrive in natural order over valid/ready, are stored in a
//               ping-pong pair of banks and leave in bit-reversed order with
//               first/last frame markers. One sample per cycle sustained
//               when downstream does not stall.
// Options     : FFT_BITREV_LAST_CHK_EN - adds src_last_in and a sticky
//               frame_err_out that flags src_last_in disagreeing with the
//               internal frame counter. Framing stays counter-driven.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_bitrev_buffer
    import fft_pkg::*;
#(
    parameter int N_POINTS   = FFT_N,
    parameter int DATA_WIDTH = FFT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  src_valid_in,
    output logic                  src_ready_out,
    input  logic [DATA_WIDTH-1:0] src_re_in,
    input  logic [DATA_WIDTH-1:0] src_im_in,
    output logic                  dst_valid_out,
    input  logic                  dst_ready_in,
    output logic [DATA_WIDTH-1:0] dst_re_out,
    output logic [DATA_WIDTH-1:0] dst_im_out,
    output logic                  dst_first_out,
    output logic                  dst_last_out
`ifdef FFT_BITREV_LAST_CHK_EN
    ,
    input  logic                  src_last_in,
    output logic                  frame_err_out
`endif
);

    localparam int                    ADDR_WIDTH = $clog2(N_POINTS);
    localparam int                    WORD_WIDTH = 2 * DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(N_POINTS - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    // init_q holds src_ready_out low until the first edge after reset.
    logic                  init_q,      init_d;
    logic                  wr_bank_q,   wr_bank_d;
    logic                  rd_bank_q,   rd_bank_d;
    logic [ADDR_WIDTH-1:0] wr_idx_q,    wr_idx_d;
    logic [ADDR_WIDTH-1:0] rd_idx_q,    rd_idx_d;
    bank_state_e           bank_state_q [2];
    bank_state_e           bank_state_d [2];

    logic                  dst_valid_q, dst_valid_d;
    logic [DATA_WIDTH-1:0] dst_re_q,    dst_re_d;
    logic [DATA_WIDTH-1:0] dst_im_q,    dst_im_d;
    logic                  dst_first_q, dst_first_d;
    logic                  dst_last_q,  dst_last_d;

    // ------------------------------------------------------------------
    // Combinational handshake and addressing
    // ------------------------------------------------------------------
    logic                  src_accept;
    logic                  rd_readable;
    logic                  rd_load;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [WORD_WIDTH-1:0] wr_word;
    logic [WORD_WIDTH-1:0] rd_word;
    logic [WORD_WIDTH-1:0] bank_rd_data [2];

    // Ready depends only on bank flags, never on src_valid_in.
    assign src_ready_out = init_q && (bank_state_q[wr_bank_q] == BANK_EMPTY);
    assign src_accept    = src_valid_in && src_ready_out;

    assign rd_readable   = (bank_state_q[rd_bank_q] == BANK_FULL);
    // Load when the output register is empty or being consumed this cycle.
    assign rd_load       = rd_readable && (!dst_valid_q || dst_ready_in);

    assign rd_addr       = ADDR_WIDTH'(bitrev(32'(rd_idx_q), ADDR_WIDTH));
    assign wr_word       = {src_re_in, src_im_in};
    assign rd_word       = bank_rd_data[rd_bank_q];

    // ------------------------------------------------------------------
    // Ping-pong storage banks
    // ------------------------------------------------------------------
    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_bank_ram #(
            .DEPTH      (N_POINTS),
            .WIDTH      (WORD_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_bank_ram (
            .clk         (clk),
            .wr_en_in    (src_accept && (wr_bank_q == 1'(b))),
            .wr_addr_in  (wr_idx_q),
            .wr_data_in  (wr_word),
            .rd_addr_in  (rd_addr),
            .rd_data_out (bank_rd_data[b])
        );
    end

    // ------------------------------------------------------------------
    // Next-state: write pointer, read pointer, bank flags, output register
    // ------------------------------------------------------------------
    // A bank is only written while EMPTY and only read while FULL, so the
    // fill and drain updates below always target different banks and can
    // both take effect in the same cycle.
    always_comb begin
        init_d       = 1'b1;
        wr_bank_d    = wr_bank_q;
        rd_bank_d    = rd_bank_q;
        wr_idx_d     = wr_idx_q;
        rd_idx_d     = rd_idx_q;
        bank_state_d = bank_state_q;
        dst_valid_d  = dst_valid_q;
        dst_re_d     = dst_re_q;
        dst_im_d     = dst_im_q;
        dst_first_d  = dst_first_q;
        dst_last_d   = dst_last_q;

        // Write side: fill the current bank in natural order.
        if (src_accept) begin
            wr_idx_d = wr_idx_q + 1'b1;
            if (wr_idx_q == LAST_IDX) begin
                bank_state_d[wr_bank_q] = BANK_FULL;
                wr_bank_d               = ~wr_bank_q;
            end
        end

        // Read side: walk the full bank in bit-reversed order.
        if (rd_load) begin
            dst_valid_d = 1'b1;
            dst_re_d    = rd_word[WORD_WIDTH-1:DATA_WIDTH];
            dst_im_d    = rd_word[DATA_WIDTH-1:0];
            dst_first_d = (rd_idx_q == '0);
            dst_last_d  = (rd_idx_q == LAST_IDX);
            rd_idx_d    = rd_idx_q + 1'b1;
            if (rd_idx_q == LAST_IDX) begin
                bank_state_d[rd_bank_q] = BANK_EMPTY;
                rd_bank_d               = ~rd_bank_q;
            end
        end else if (dst_ready_in) begin
            dst_valid_d = 1'b0;
        end
    end

    // State register with asynchronous reset discarding all stored frames.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            init_q          <= 1'b0;
            wr_bank_q       <= 1'b0;
            rd_bank_q       <= 1'b0;
            wr_idx_q        <= '0;
            rd_idx_q        <= '0;
            bank_state_q[0] <= BANK_EMPTY;
            bank_state_q[1] <= BANK_EMPTY;
            dst_valid_q     <= 1'b0;
            dst_re_q        <= '0;
            dst_im_q        <= '0;
            dst_first_q     <= 1'b0;
            dst_last_q      <= 1'b0;
        end else begin
            init_q          <= init_d;
            wr_bank_q       <= wr_bank_d;
            rd_bank_q       <= rd_bank_d;
            wr_idx_q        <= wr_idx_d;
            rd_idx_q        <= rd_idx_d;
            bank_state_q    <= bank_state_d;
            dst_valid_q     <= dst_valid_d;
            dst_re_q        <= dst_re_d;
            dst_im_q        <= dst_im_d;
            dst_first_q     <= dst_first_d;
            dst_last_q      <= dst_last_d;
        end
    end

    assign dst_valid_out = dst_valid_q;
    assign dst_re_out    = dst_re_q;
    assign dst_im_out    = dst_im_q;
    assign dst_first_out = dst_first_q;
    assign dst_last_out  = dst_last_q;

`ifdef FFT_BITREV_LAST_CHK_EN
    // ------------------------------------------------------------------
    // Framing check: src_last_in must agree with the write counter.
    // ------------------------------------------------------------------
    logic frame_err_q, frame_err_d;

    // Sticky error: set on any accepted sample whose last flag disagrees.
    always_comb begin
        frame_err_d = frame_err_q;
        if (src_accept && (src_last_in != (wr_idx_q == LAST_IDX))) begin
            frame_err_d = 1'b1;
        end
    end

    // Error flag register, cleared only by reset.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_err_out = frame_err_q;
`endif

endmodule : fft_bitrev_buffer
`default_nettype wire
